// File: rtl/fir_interp_poly_pkg.sv
// fir_pkg: shared helpers and FSM encoding for the polyphase FIR family
package fir_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2;
  function automatic int clog2(input int n);
    int r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int acc_width(input int dw, input int cw, input int m);
    return dw + cw + clog2(m) + 1;
  endfunction
  function automatic logic signed [63:0] sat(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return x > hi ? hi : x < lo ? lo : x;
  endfunction
endpackage

// File: rtl/fir_interp_poly_if.sv
// fir_interp_poly_if: valid/ready sample input and phase-tagged sample output
interface fir_interp_poly_if #(parameter int DW = 16, parameter int PW = 2);
  logic s_valid, s_ready, m_valid, m_ready;
  logic signed [DW-1:0] s_data, m_data;
  logic [PW-1:0] m_phase;
  modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data, m_phase);
  modport slave (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data, m_phase);
endinterface

// File: rtl/fir_interp_poly_mac_unit.sv
// fir_mac_unit: clear/enable multiply-accumulate with round, shift and saturate stage
// FIR_INTERP_ROUND_EN selects round-half-up instead of floor before the shift
module fir_mac_unit import fir_pkg::*; #(
  parameter int DW = 16,
  parameter int CW = 16,
  parameter int AW = 37,
  parameter int SHIFT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic signed [DW-1:0] a_i,
  input  logic signed [CW-1:0] b_i,
  output logic signed [DW-1:0] y_o
);
  logic signed [AW-1:0] acc_q, acc_d, rnd;
  logic signed [DW+CW-1:0] prod;
  logic signed [63:0] sh;
  always_comb begin
    prod = (DW+CW)'(a_i) * (DW+CW)'(b_i);
    acc_d = clr_i ? '0 : en_i ? acc_q + AW'(prod) : acc_q;
`ifdef FIR_INTERP_ROUND_EN
    rnd = acc_q + AW'((64'd1 << SHIFT) >> 1);
`else
    rnd = acc_q;
`endif
    sh = 64'(rnd >>> SHIFT);
    y_o = DW'(sat(sh, DW));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc_q <= '0;
    else acc_q <= acc_d;
endmodule

// File: rtl/fir_interp_poly.sv
// fir_interp_poly: polyphase interpolate-by-L FIR built around one shared MAC
// FIR_INTERP_ROUND_EN (consumed by fir_mac_unit) enables round-half-up on the output
module fir_interp_poly import fir_pkg::*; #(
  parameter int N_TAPS = 63,
  parameter int L = 4,
  parameter int DW = 16,
  parameter int CW = 16,
  parameter logic [N_TAPS*CW-1:0] COEF = {
    16'hFFF0, 16'hFFE8, 16'hFFE0, 16'hFFE4, 16'hFFF4, 16'h000C, 16'h0024, 16'h0038,
    16'h003C, 16'h0028, 16'h0000, 16'hFFC8, 16'hFF90, 16'hFF70, 16'hFF74, 16'hFFA4,
    16'h0000, 16'h0074, 16'h00E0, 16'h0120, 16'h0120, 16'h00D0, 16'h0030, 16'hFF5C,
    16'hFE90, 16'hFE10, 16'hFE20, 16'hFF00, 16'h00E0, 16'h03A0, 16'h06E0, 16'h0800,
    16'h06E0, 16'h03A0, 16'h00E0, 16'hFF00, 16'hFE20, 16'hFE10, 16'hFE90, 16'hFF5C,
    16'h0030, 16'h00D0, 16'h0120, 16'h0120, 16'h00E0, 16'h0074, 16'h0000, 16'hFFA4,
    16'hFF74, 16'hFF70, 16'hFF90, 16'hFFC8, 16'h0000, 16'h0028, 16'h003C, 16'h0038,
    16'h0024, 16'h000C, 16'hFFF4, 16'hFFE4, 16'hFFE0, 16'hFFE8, 16'hFFF0},
  parameter int SHIFT = 15
) (
  input logic clk,
  input logic rst_n,
  fir_interp_poly_if.slave bus
);
  localparam int M = (N_TAPS + L - 1) / L;
  localparam int KW = clog2(M), PW = clog2(L), IW = clog2(M * L);
  localparam int AW = acc_width(DW, CW, M);
  state_t st_q, st_d;
  logic [KW-1:0] k_q, k_d;
  logic [PW-1:0] p_q, p_d;
  logic rdy_q, accept, acc_clr, last_k, last_p;
  logic [IW-1:0] idx;
  logic signed [DW-1:0] d_q [M];
  logic signed [CW-1:0] h [M*L];
  logic signed [DW-1:0] y;
  // Zero-pad the prototype up to M*L taps so every phase has exactly M taps
  for (genvar i = 0; i < M * L; i++) begin : g_h
    if (i < N_TAPS) begin : g_t
      assign h[i] = COEF[(N_TAPS-1-i)*CW +: CW];
    end else begin : g_z
      assign h[i] = '0;
    end
  end
  always_comb begin
    accept = st_q == IDLE && rdy_q && bus.s_valid;
    last_k = k_q == KW'(M - 1);
    last_p = p_q == PW'(L - 1);
    idx = IW'(k_q) * IW'(L) + IW'(p_q);
    acc_clr = accept || (st_q == OUT && bus.m_ready && !last_p);
    st_d = accept ? MAC : st_q == MAC && last_k ? OUT :
           st_q == OUT && bus.m_ready ? (last_p ? IDLE : MAC) : st_q;
    k_d = st_q == MAC && !last_k ? k_q + 1'b1 : '0;
    p_d = accept ? '0 : acc_clr ? p_q + 1'b1 : p_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q <= IDLE;
      k_q <= '0;
      p_q <= '0;
      rdy_q <= 1'b0;
      for (int j = 0; j < M; j++) d_q[j] <= '0;
    end else begin
      st_q <= st_d;
      k_q <= k_d;
      p_q <= p_d;
      rdy_q <= 1'b1;
      if (accept) begin
        d_q[0] <= bus.s_data;
        for (int j = 1; j < M; j++) d_q[j] <= d_q[j-1];
      end
    end
  fir_mac_unit #(.DW(DW), .CW(CW), .AW(AW), .SHIFT(SHIFT)) u_mac (
    .clk(clk), .rst_n(rst_n), .clr_i(acc_clr), .en_i(st_q == MAC),
    .a_i(d_q[k_q]), .b_i(h[idx]), .y_o(y)
  );
  assign bus.s_ready = st_q == IDLE && rdy_q;
  assign bus.m_valid = st_q == OUT;
  assign bus.m_phase = p_q;
  assign bus.m_data = y;
endmodule
